// File: rtl/code_mem_loader_pkg.sv
// Shared definitions for the code memory loader: FSM state encoding and packing ratio.
package code_mem_loader_pkg;

   localparam int BYTES_PER_WORD = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LO,
      ST_HI,
      ST_WR,
      ST_CHK_LO,
      ST_CHK_HI,
      ST_FIN
   } state_t;

endpackage

// File: rtl/code_mem_loader_packer.sv
// byte_to_word_packer: assembles two stream bytes little-endian into one word.
// The low byte is registered; the high byte is combined combinationally on its transfer cycle.
module byte_to_word_packer
   import code_mem_loader_pkg::*;
(
   input  logic                        clk,
   input  logic                        resetn,
   input  logic                        take_lo,
   input  logic                        take_hi,
   input  logic [7:0]                  s_data,
   input  logic                        s_valid,
   output logic                        s_ready,
   output logic                        lo_fire,
   output logic                        hi_fire,
   output logic [8*BYTES_PER_WORD-1:0] word
);

   logic [7:0] lo_reg;

   assign s_ready = take_lo | take_hi;
   assign lo_fire = take_lo & s_valid;
   assign hi_fire = take_hi & s_valid;
   assign word    = {s_data, lo_reg};

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         lo_reg <= '0;
      end else if (lo_fire) begin
         lo_reg <= s_data;
      end
   end

endmodule

// File: rtl/code_mem_loader.sv
// Streams byte pairs into sequential code memory words while holding the CPU in reset.
// Optional checksum trailer and sticky error flag: define CODE_MEM_LOADER_CHECKSUM_EN.
module code_mem_loader
   import code_mem_loader_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH:0]   word_count,
   input  logic [7:0]            s_data,
   input  logic                  s_valid,
   output logic                  s_ready,
   output logic [ADDR_WIDTH-1:0] mem_addr_w,
   output logic [DATA_WIDTH-1:0] mem_data_in,
   output logic                  mem_we,
   output logic                  cpu_reset,
   output logic                  busy,
   output logic                  done,
   output logic                  error
);

   state_t                  state_reg, state_next;
   logic [ADDR_WIDTH-1:0]   addr_reg;
   logic [ADDR_WIDTH:0]     remaining_reg;
   logic [ADDR_WIDTH-1:0]   mem_addr_reg;
   logic [DATA_WIDTH-1:0]   mem_data_reg;
   logic                    hold_reg;
   logic                    take_lo, take_hi, lo_fire, hi_fire;
   logic [DATA_WIDTH-1:0]   word;
   logic                    release_ok;
   state_t                  after_data;

`ifdef CODE_MEM_LOADER_CHECKSUM_EN
   logic                    error_reg;
   logic [DATA_WIDTH-1:0]   sum_reg;
   assign after_data = ST_CHK_LO;
   assign release_ok = ~error_reg;
   assign error      = error_reg;
`else
   assign after_data = ST_FIN;
   assign release_ok = 1'b1;
   assign error      = 1'b0;
`endif

   assign take_lo = (state_reg == ST_LO) || (state_reg == ST_CHK_LO);
   assign take_hi = (state_reg == ST_HI) || (state_reg == ST_CHK_HI);

   byte_to_word_packer u_packer (
      .clk     (clk),
      .resetn  (resetn),
      .take_lo (take_lo),
      .take_hi (take_hi),
      .s_data  (s_data),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .lo_fire (lo_fire),
      .hi_fire (hi_fire),
      .word    (word)
   );

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:   if (start) state_next = (word_count == '0) ? after_data : ST_LO;
         ST_LO:     if (lo_fire) state_next = ST_HI;
         ST_HI:     if (hi_fire) state_next = ST_WR;
         ST_WR:     state_next = (remaining_reg == (ADDR_WIDTH+1)'(1)) ? after_data : ST_LO;
         ST_CHK_LO: if (lo_fire) state_next = ST_CHK_HI;
         ST_CHK_HI: if (hi_fire) state_next = ST_FIN;
         ST_FIN:    state_next = ST_IDLE;
         default:   state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_reg     <= ST_IDLE;
         addr_reg      <= '0;
         remaining_reg <= '0;
         mem_addr_reg  <= '0;
         mem_data_reg  <= '0;
         hold_reg      <= 1'b1;
`ifdef CODE_MEM_LOADER_CHECKSUM_EN
         error_reg     <= 1'b0;
         sum_reg       <= '0;
`endif
      end else begin
         state_reg <= state_next;
         case (state_reg)
            ST_IDLE: if (start) begin
               addr_reg      <= base_addr;
               remaining_reg <= word_count;
               hold_reg      <= 1'b1;
`ifdef CODE_MEM_LOADER_CHECKSUM_EN
               error_reg     <= 1'b0;
               sum_reg       <= '0;
`endif
            end
            // Capture the write beat one cycle early so WR drives stable registered values.
            ST_HI: if (hi_fire) begin
               mem_addr_reg <= addr_reg;
               mem_data_reg <= word;
            end
            ST_WR: begin
               addr_reg      <= addr_reg + 1'b1;
               remaining_reg <= remaining_reg - 1'b1;
`ifdef CODE_MEM_LOADER_CHECKSUM_EN
               sum_reg       <= sum_reg + mem_data_reg;
`endif
            end
`ifdef CODE_MEM_LOADER_CHECKSUM_EN
            ST_CHK_HI: if (hi_fire && (word != sum_reg)) error_reg <= 1'b1;
`endif
            ST_FIN: hold_reg <= ~release_ok;
            default: ;
         endcase
      end
   end

   assign mem_we      = (state_reg == ST_WR);
   assign mem_addr_w  = mem_addr_reg;
   assign mem_data_in = mem_data_reg;
   assign done        = (state_reg == ST_FIN);
   assign busy        = (state_reg != ST_IDLE) && (state_reg != ST_FIN);
   // The CPU is released during the completion cycle itself, not one cycle later.
   assign cpu_reset   = hold_reg & ~(done & release_ok);

endmodule

// File: tb/tb_code_mem_loader.sv
// Directed bench for code_mem_loader: reset, basic load, backpressure/wrap, edge cases,
// mid-load reset and (with CODE_MEM_LOADER_CHECKSUM_EN) checksum pass/fail.
module tb_code_mem_loader;

   logic        clk = 1'b0;
   logic        resetn = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  base_addr = '0;
   logic [8:0]  word_count = '0;
   logic [7:0]  s_data = '0;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic [7:0]  mem_addr_w;
   logic [15:0] mem_data_in;
   logic        mem_we, cpu_reset, busy, done, error;

   int total = 0;
   int bad = 0;
   int done_cnt = 0;
   logic [15:0] mem_model [256];
   logic [7:0]  log_a [$];
   logic [15:0] log_d [$];

   always #5 clk = ~clk;

   code_mem_loader #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) dut (
      .clk         (clk),
      .resetn      (resetn),
      .start       (start),
      .base_addr   (base_addr),
      .word_count  (word_count),
      .s_data      (s_data),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .mem_addr_w  (mem_addr_w),
      .mem_data_in (mem_data_in),
      .mem_we      (mem_we),
      .cpu_reset   (cpu_reset),
      .busy        (busy),
      .done        (done),
      .error       (error)
   );

   // Code memory model and write log, sampled mid-cycle.
   always @(negedge clk) begin
      if (mem_we) begin
         log_a.push_back(mem_addr_w);
         log_d.push_back(mem_data_in);
         mem_model[mem_addr_w] = mem_data_in;
         $display("write addr=%02h data=%04h", mem_addr_w, mem_data_in);
      end
      if (done) done_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_start(input logic [7:0] b, input logic [8:0] c);
      start = 1'b1;
      base_addr = b;
      word_count = c;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int n;
      s_valid = 1'b0;
      repeat (gap) @(negedge clk);
      s_data = b;
      s_valid = 1'b1;
      n = 0;
      while (!s_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) check("s_ready_timeout", {31'd0, s_ready}, 32'd1);
      @(negedge clk);
      s_valid = 1'b0;
   endtask

   task automatic send_word(input logic [15:0] w, input int gap);
      send_byte(w[7:0], gap);
      send_byte(w[15:8], gap);
   endtask

   // Checksum trailer; only consumed when the feature is compiled in.
   task automatic send_chk(input logic [15:0] w);
`ifdef CODE_MEM_LOADER_CHECKSUM_EN
      send_word(w, 0);
`else
      if (w === 16'hxxxx) $display("unused checksum");
`endif
   endtask

   task automatic wait_done(input int limit, input string tag);
      int n;
      n = 0;
      while (!done && n < limit) begin
         @(negedge clk);
         n++;
      end
      check(tag, {31'd0, done}, 32'd1);
      @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem_model[i] = '0;

      // 1. reset
      #2 resetn = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
         check("rst_busy", {31'd0, busy}, 32'd0);
         check("rst_s_ready", {31'd0, s_ready}, 32'd0);
         check("rst_mem_we", {31'd0, mem_we}, 32'd0);
      end
      check("rst_addr", {24'd0, mem_addr_w}, 32'd0);
      check("rst_data", {16'd0, mem_data_in}, 32'd0);
      check("rst_done_err", {30'd0, done, error}, 32'd0);
      resetn = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("idle_cpu_hold", {31'd0, cpu_reset}, 32'd1);

      // 2. basic load
      do_start(8'h00, 9'd3);
      check("b_busy", {31'd0, busy}, 32'd1);
      check("b_cpu_reset", {31'd0, cpu_reset}, 32'd1);
      check("b_ready", {31'd0, s_ready}, 32'd1);
      send_word(16'h2011, 0);
      send_word(16'h2050, 0);
      send_word(16'h03B1, 0);
      send_chk(16'h4412);
      wait_done(20, "b_done");
      check("b_nwrites", log_a.size(), 32'd3);
      check("b_a0", {24'd0, log_a[0]}, 32'h00);
      check("b_d0", {16'd0, log_d[0]}, 32'h2011);
      check("b_a1", {24'd0, log_a[1]}, 32'h01);
      check("b_d1", {16'd0, log_d[1]}, 32'h2050);
      check("b_a2", {24'd0, log_a[2]}, 32'h02);
      check("b_d2", {16'd0, log_d[2]}, 32'h03B1);
      check("b_done_cnt", done_cnt, 32'd1);
      check("b_cpu_release", {31'd0, cpu_reset}, 32'd0);
      check("b_idle", {30'd0, busy, mem_we}, 32'd0);
      check("b_hold_addr", {24'd0, mem_addr_w}, 32'h02);
      check("b_rd1", {16'd0, mem_model[1]}, 32'h2050);

      // 3. backpressure and wrap
      log_a.delete(); log_d.delete();
      do_start(8'hFE, 9'd3);
      check("w_cpu_reset", {31'd0, cpu_reset}, 32'd1);
      send_word(16'hAA55, $urandom_range(0, 3));
      send_word(16'h1234, $urandom_range(0, 3));
      send_word(16'hBEEF, $urandom_range(0, 3));
      send_chk(16'h7B78);
      wait_done(200, "w_done");
      check("w_nwrites", log_a.size(), 32'd3);
      check("w_a0", {24'd0, log_a[0]}, 32'hFE);
      check("w_d0", {16'd0, log_d[0]}, 32'hAA55);
      check("w_a1", {24'd0, log_a[1]}, 32'hFF);
      check("w_d1", {16'd0, log_d[1]}, 32'h1234);
      check("w_a2", {24'd0, log_a[2]}, 32'h00);
      check("w_d2", {16'd0, log_d[2]}, 32'hBEEF);
      check("w_rd0", {16'd0, mem_model[0]}, 32'hBEEF);
      check("w_rd1_kept", {16'd0, mem_model[1]}, 32'h2050);

      // 4a. zero-length load
      log_a.delete(); log_d.delete();
      done_cnt = 0;
      do_start(8'h20, 9'd0);
`ifdef CODE_MEM_LOADER_CHECKSUM_EN
      send_chk(16'h0000);
      wait_done(10, "z_done");
`else
      wait_done(2, "z_done");
`endif
      check("z_nwrites", log_a.size(), 32'd0);
      check("z_done_cnt", done_cnt, 32'd1);
      check("z_cpu_release", {31'd0, cpu_reset}, 32'd0);

      // 4b. start while busy is ignored
      done_cnt = 0;
      do_start(8'h10, 9'd2);
      send_word(16'h0102, 0);
      start = 1'b1; base_addr = 8'h80; word_count = 9'd1;
      @(negedge clk);
      start = 1'b0;
      send_word(16'h0304, 0);
      send_chk(16'h0406);
      wait_done(20, "x_done");
      check("x_nwrites", log_a.size(), 32'd2);
      check("x_a0", {24'd0, log_a[0]}, 32'h10);
      check("x_d0", {16'd0, log_d[0]}, 32'h0102);
      check("x_a1", {24'd0, log_a[1]}, 32'h11);
      check("x_d1", {16'd0, log_d[1]}, 32'h0304);
      check("x_done_cnt", done_cnt, 32'd1);
      check("x_rd80", {16'd0, mem_model[8'h80]}, 32'h0000);

      // 5. reset mid-load after three bytes
      log_a.delete(); log_d.delete();
      do_start(8'h30, 9'd2);
      send_word(16'h2211, 0);
      send_byte(8'h33, 0);
      resetn = 1'b0;
      #1;
      check("m_cpu_reset", {31'd0, cpu_reset}, 32'd1);
      check("m_busy", {31'd0, busy}, 32'd0);
      check("m_ready", {31'd0, s_ready}, 32'd0);
      check("m_out", {7'd0, mem_we, mem_addr_w, mem_data_in}, 32'd0);
      check("m_partial", log_a.size(), 32'd1);
      check("m_rd30", {16'd0, mem_model[8'h30]}, 32'h2211);
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      do_start(8'h40, 9'd1);
      send_word(16'h1234, 1);
      send_chk(16'h1234);
      wait_done(20, "m2_done");
      check("m2_nwrites", log_a.size(), 32'd2);
      check("m2_a", {24'd0, log_a[1]}, 32'h40);
      check("m2_d", {16'd0, log_d[1]}, 32'h1234);
      check("m2_cpu_release", {31'd0, cpu_reset}, 32'd0);
      check("m2_error", {31'd0, error}, 32'd0);

`ifdef CODE_MEM_LOADER_CHECKSUM_EN
      // 6. checksum pass then fail
      do_start(8'h50, 9'd2);
      send_word(16'h0001, 0);
      send_word(16'h0002, 0);
      send_chk(16'h0003);
      wait_done(20, "c_done_ok");
      check("c_err_ok", {31'd0, error}, 32'd0);
      check("c_cpu_ok", {31'd0, cpu_reset}, 32'd0);
      done_cnt = 0;
      do_start(8'h50, 9'd2);
      send_word(16'h0001, 0);
      send_word(16'h0002, 0);
      send_chk(16'h0004);
      wait_done(20, "c_done_bad");
      check("c_err_bad", {31'd0, error}, 32'd1);
      check("c_cpu_held", {31'd0, cpu_reset}, 32'd1);
      check("c_done_cnt", done_cnt, 32'd1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/code_mem_loader.md
Name: code_mem_loader

Overview:
Writer side of the 16-bit code memory write port (addr_w/data_in/we). Takes a byte stream (valid/ready), packs byte pairs little-endian into instruction words and writes them to sequential addresses from a start address. Holds the CPU in reset during the load and releases it on completion. Sits between the host byte link (UART RX or bus bridge) and the code memory.

Parameters:
DATA_WIDTH, 16, code word width; fixed at 16 (two bytes per word).
ADDR_WIDTH, 8, code memory address width.

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a load (ignored unless IDLE)
base_addr  in  ADDR_WIDTH  first write address, sampled on start
word_count  in  ADDR_WIDTH+1  words to load, 0..2^ADDR_WIDTH, sampled on start
s_data  in  8  stream byte
s_valid  in  1  stream byte valid
s_ready  out  1  loader accepts byte this cycle
mem_addr_w  out  ADDR_WIDTH  to code memory addr_w
mem_data_in  out  DATA_WIDTH  to code memory data_in
mem_we  out  1  to code memory we
cpu_reset  out  1  active-high CPU hold
busy  out  1  load in progress
done  out  1  one-cycle pulse at load completion
error  out  1  sticky checksum error (macro only; tied 0 otherwise)

Behaviour:
- Reset values: s_ready=0, mem_we=0, mem_addr_w=0, mem_data_in=0, cpu_reset=1, busy=0, done=0, error=0. cpu_reset remains 1 after reset until the first completed load.
- States: IDLE, LO, HI, WR, (CHK_LO, CHK_HI with macro), FIN.
- IDLE: s_ready=0. On start: latch base_addr into addr, word_count into remaining, clear error, set busy=1 and cpu_reset=1. Go to FIN if word_count==0, otherwise to LO.
- LO: s_ready=1. A byte transfers when s_valid&&s_ready. It becomes word[7:0]. Go to HI.
- HI: s_ready=1. On transfer the byte becomes word[15:8]. Go to WR.
- WR: s_ready=0. mem_we=1 for exactly one cycle with mem_addr_w=addr and mem_data_in=word. Then addr+=1, wrapping modulo 2^ADDR_WIDTH, and remaining-=1. Go to LO if remaining!=0, otherwise to FIN (or CHK_LO with macro).
- FIN: done=1 for one cycle, busy=0, cpu_reset=0. Go to IDLE.
- Throughput: one word per 3 cycles at full s_valid. s_valid low stalls LO/HI indefinitely with no timeout.
- mem_we is asserted only in WR. mem_addr_w and mem_data_in hold their last values otherwise.
- start while busy is ignored. A new start from IDLE re-asserts cpu_reset in the same cycle the start is registered.
- Address wrap: base_addr+word_count > 2^ADDR_WIDTH wraps to 0 and overwrites from 0. word_count=2^ADDR_WIDTH fills the whole memory exactly once.
- resetn low mid-load: return to IDLE immediately with all outputs at reset values. The partial load stays in memory and cpu_reset=1.

Optional Feature:
Macro CODE_MEM_LOADER_CHECKSUM_EN.
- Enabled:
  - A 16-bit modular sum of all written words is accumulated.
  - After the last WR, two more bytes (CHK_LO, CHK_HI; s_ready=1) form the checksum word.
  - On mismatch, error=1 (sticky until the next start) and FIN keeps cpu_reset=1. done still pulses.
  - word_count=0 still expects a checksum of 0x0000.
- Disabled: no checksum bytes are consumed, error is tied to 0, and FIN always releases cpu_reset.

Decomposition:
- Shared package code_mem_loader_pkg holds the state encoding enum/localparams and BYTES_PER_WORD=2.
- One natural sub-module, byte_to_word_packer (LO/HI byte assembly with valid/ready). The address counter and FSM stay in the top module.

Test Plan:
1. Reset: drive resetn=0 -> cpu_reset=1, busy=0, s_ready=0, mem_we=0 in every cycle of reset.
2. Basic load: start with base=0x00, count=3, bytes 11 20 50 20 B1 03 -> writes 0x2011@0x00, 0x2050@0x01, 0x03B1@0x02. done pulses once, then cpu_reset=0. Readback via the code memory read port matches.
3. Backpressure and wrap: base=0xFE, count=3, s_valid toggling randomly -> writes at 0xFE, 0xFF, 0x00 in order, data intact, no duplicate mem_we.
4. Edge cases: count=0 -> done pulses within 2 cycles and mem_we never asserts. A start pulse during a busy load -> ignored, and the in-flight load completes unchanged.
5. Reset mid-load: resetn=0 after 3 bytes -> IDLE, cpu_reset=1. A subsequent clean load of count=1 succeeds.
6. Checksum (macro on): words 0x0001, 0x0002 with checksum 0x0003 -> error=0, cpu_reset=0. The same words with checksum 0x0004 -> error=1, cpu_reset stays 1.
